// File: rtl/ram_fifo_ctrl.sv
// FIFO sequencer for a synchronous dual-port RAM: turns push/pop requests into
// RAM strobes and addresses, tracks occupancy and returns read data with a valid strobe.
module ram_fifo_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_BUS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_BUS:0]     count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_BUS-1:0]   ram_wr_addr,
    output logic [ADDR_BUS-1:0]   ram_rd_addr,
    output logic [WIDTH-1:0]      ram_din,
    input  logic [WIDTH-1:0]      ram_dout
);

    localparam int unsigned CNT_W = ADDR_BUS + 1;

    logic [ADDR_BUS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BUS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                pop_valid_q, pop_valid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                push_acc;
    logic                pop_acc;

    // Status decode and accept rules from the pre-edge state; nothing is accepted in reset.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == CNT_W'(0));
        push_acc = push & ~full & ~rst;
        pop_acc  = pop & ~empty & ~rst;
    end

    // RAM drive and output mapping; read data is only presented alongside its valid strobe.
    always_comb begin
        ram_we      = push_acc;
        ram_wr_addr = wr_ptr_q;
        ram_din     = rst ? WIDTH'(0) : push_data;
        ram_re      = pop_acc;
        ram_rd_addr = rd_ptr_q;
        pop_valid   = pop_valid_q;
        pop_data    = pop_valid_q ? ram_dout : WIDTH'(0);
        count       = count_q;
        overflow    = overflow_q;
        underflow   = underflow_q;
    end

    // Next-state: pointers wrap naturally at 2**ADDR_BUS, count tracks net occupancy.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_valid_d = pop_acc;
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_BUS'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_BUS'(1);
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; a read in flight at reset is dropped by clearing pop_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
